mips_hazard_unit: RTL

Parametrised hazard-detection and forwarding controller for the five-stage MIPS pipeline. It tracks in-flight register writes in a scoreboard shift register that mirrors the ID/EX, EX/MEM and MEM/WB pipeline registers. It generates load-use stalls, bubble insertion, branch flushes and registered forwarding selects for the EX-stage operand muxes. It sits beside the pipeline registers and drives their enables and clears.

---
 rtl/mips_pkg.sv | 24 ++
 rtl/mips_hazard_unit_scoreboard.sv | 66 ++++++
 rtl/mips_hazard_unit.sv | 149 ++++++++++++++
 3 files changed

// File: rtl/mips_pkg.sv
// Shared scoreboard types and constants for the MIPS pipeline control blocks.
// Register addresses up to SB_DEST_W bits wide are supported.
package mips_pkg;

  localparam int SB_DEST_W = 8;
  localparam int FWD_RF    = 0;
  localparam logic [SB_DEST_W-1:0] REG_ZERO = {SB_DEST_W{1'b0}};

  typedef struct packed {
    logic                 valid;
    logic [SB_DEST_W-1:0] dest;
    logic                 isLoad;
  } sbEntry_t;

  function automatic logic sbMatch(
    input logic                 used,
    input logic                 valid,
    input logic [SB_DEST_W-1:0] dest,
    input logic [SB_DEST_W-1:0] src
  );
    return used & valid & (dest == src);
  endfunction

endpackage

// File: rtl/mips_hazard_unit_scoreboard.sv
// In-flight register-write scoreboard: entry 0 mirrors ID/EX, the last entry mirrors MEM/WB.
// Provides per-entry source-match vectors for the ID instruction.
module hazard_scoreboard
  import mips_pkg::*;
#(
  parameter int REG_ADDR_W = 5,
  parameter int PIPE_DEPTH = 3
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  newValid,
  input  logic [REG_ADDR_W-1:0] newDest,
  input  logic                  newIsLoad,
  input  logic                  bubble,
  input  logic                  killMem,
  input  logic [REG_ADDR_W-1:0] rs,
  input  logic [REG_ADDR_W-1:0] rt,
  input  logic                  usesRs,
  input  logic                  usesRt,
  output logic [PIPE_DEPTH-1:0] rsMatch,
  output logic [PIPE_DEPTH-1:0] rtMatch,
  output logic                  headIsLoad
);

  sbEntry_t entries_r [PIPE_DEPTH];
  sbEntry_t head_s;

  // Entry entering EX: a bubble when the ID instruction is held or squashed.
  always_comb begin
    head_s.valid  = newValid & ~bubble;
    head_s.dest   = SB_DEST_W'(newDest);
    head_s.isLoad = newIsLoad & ~bubble;
  end

  // Shift toward WB; the old EX instruction dies on its way into MEM when killed.
  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int k = 0; k < PIPE_DEPTH; k++) begin
        entries_r[k] <= {1'b0, REG_ZERO, 1'b0};
      end
    end else begin
      entries_r[0] <= head_s;
      for (int k = 1; k < PIPE_DEPTH; k++) begin
        entries_r[k] <= entries_r[k-1];
      end
      if (killMem) begin
        entries_r[1].valid <= 1'b0;
      end else begin
        entries_r[1].valid <= entries_r[0].valid;
      end
    end
  end

  // Source-versus-entry comparison for both operands.
  always_comb begin
    rsMatch = {PIPE_DEPTH{1'b0}};
    rtMatch = {PIPE_DEPTH{1'b0}};
    for (int k = 0; k < PIPE_DEPTH; k++) begin
      rsMatch[k] = sbMatch(usesRs, entries_r[k].valid, entries_r[k].dest, SB_DEST_W'(rs));
      rtMatch[k] = sbMatch(usesRt, entries_r[k].valid, entries_r[k].dest, SB_DEST_W'(rt));
    end
  end

  assign headIsLoad = entries_r[0].isLoad;

endmodule

// File: rtl/mips_hazard_unit.sv
// Hazard detection, branch flush and EX forwarding control for the five-stage MIPS pipeline.
// Define MIPS_HAZARD_FWD_EN for forwarding; otherwise any pending write interlocks the reader.
module mips_hazard_unit
  import mips_pkg::*;
#(
  parameter int REG_ADDR_W = 5,
  parameter int PIPE_DEPTH = 3,
  parameter int FWD_W      = $clog2(PIPE_DEPTH + 1),
  parameter int CNT_W      = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  id_valid,
  input  logic [REG_ADDR_W-1:0] id_rs,
  input  logic [REG_ADDR_W-1:0] id_rt,
  input  logic                  id_uses_rs,
  input  logic                  id_uses_rt,
  input  logic                  id_reg_write,
  input  logic                  id_mem_read,
  input  logic [REG_ADDR_W-1:0] id_write_reg,
  input  logic                  branch_taken,
  output logic                  pc_en,
  output logic                  if_id_en,
  output logic                  if_id_flush,
  output logic                  id_ex_flush,
  output logic                  ex_mem_flush,
  output logic [FWD_W-1:0]      fwd_a_sel,
  output logic [FWD_W-1:0]      fwd_b_sel,
  output logic [CNT_W-1:0]      stall_count,
  output logic [CNT_W-1:0]      flush_count
);

  logic [PIPE_DEPTH-1:0] rsMatch_s;
  logic [PIPE_DEPTH-1:0] rtMatch_s;
  logic                  headIsLoad_s;
  logic                  headHit_s;
  logic                  hazard_s;
  logic                  stall_s;
  logic                  flush_s;
  logic                  newValid_s;
  logic [CNT_W-1:0]      stallCnt_r;
  logic [CNT_W-1:0]      flushCnt_r;

  assign newValid_s = id_valid & id_reg_write & (SB_DEST_W'(id_write_reg) != REG_ZERO);

  hazard_scoreboard #(
    .REG_ADDR_W (REG_ADDR_W),
    .PIPE_DEPTH (PIPE_DEPTH)
  ) uScoreboard (
    .clk        (clk),
    .reset      (reset),
    .newValid   (newValid_s),
    .newDest    (id_write_reg),
    .newIsLoad  (id_mem_read),
    .bubble     (stall_s | flush_s),
    .killMem    (flush_s),
    .rs         (id_rs),
    .rt         (id_rt),
    .usesRs     (id_uses_rs),
    .usesRt     (id_uses_rt),
    .rsMatch    (rsMatch_s),
    .rtMatch    (rtMatch_s),
    .headIsLoad (headIsLoad_s)
  );

  // Stall/flush decode; a taken branch always suppresses the stall.
  always_comb begin
    headHit_s = (rsMatch_s[0] | rtMatch_s[0]) & headIsLoad_s;
`ifdef MIPS_HAZARD_FWD_EN
    hazard_s  = headHit_s;
`else
    hazard_s  = (|(rsMatch_s | rtMatch_s)) | headHit_s;
`endif
    flush_s   = branch_taken;
    if (branch_taken) begin
      stall_s = 1'b0;
    end else begin
      stall_s = id_valid & hazard_s;
    end
  end

  assign pc_en        = ~stall_s;
  assign if_id_en     = ~stall_s;
  assign if_id_flush  = flush_s;
  assign id_ex_flush  = stall_s | flush_s;
  assign ex_mem_flush = flush_s;

  // Saturating stall and flush event counters.
  always_ff @(posedge clk) begin
    if (!reset) begin
      stallCnt_r <= {CNT_W{1'b0}};
      flushCnt_r <= {CNT_W{1'b0}};
    end else begin
      if (stall_s && (stallCnt_r != {CNT_W{1'b1}})) begin
        stallCnt_r <= stallCnt_r + CNT_W'(1);
      end else begin
        stallCnt_r <= stallCnt_r;
      end
      if (flush_s && (flushCnt_r != {CNT_W{1'b1}})) begin
        flushCnt_r <= flushCnt_r + CNT_W'(1);
      end else begin
        flushCnt_r <= flushCnt_r;
      end
    end
  end

  assign stall_count = stallCnt_r;
  assign flush_count = flushCnt_r;

`ifdef MIPS_HAZARD_FWD_EN
  logic [FWD_W-1:0] nextFwdA_s;
  logic [FWD_W-1:0] nextFwdB_s;
  logic [FWD_W-1:0] fwdA_r;
  logic [FWD_W-1:0] fwdB_r;

  // Youngest usable producer per operand; a load still in EX cannot forward yet.
  always_comb begin
    nextFwdA_s = FWD_W'(FWD_RF);
    nextFwdB_s = FWD_W'(FWD_RF);
    if (stall_s || flush_s) begin
      nextFwdA_s = FWD_W'(FWD_RF);
      nextFwdB_s = FWD_W'(FWD_RF);
    end else begin
      for (int k = PIPE_DEPTH - 1; k >= 0; k--) begin
        nextFwdA_s = (rsMatch_s[k] && ((k != 0) || !headIsLoad_s)) ? FWD_W'(k + 1) : nextFwdA_s;
        nextFwdB_s = (rtMatch_s[k] && ((k != 0) || !headIsLoad_s)) ? FWD_W'(k + 1) : nextFwdB_s;
      end
    end
  end

  // Selects travel with the instruction across the ID->EX edge.
  always_ff @(posedge clk) begin
    if (!reset) begin
      fwdA_r <= FWD_W'(FWD_RF);
      fwdB_r <= FWD_W'(FWD_RF);
    end else begin
      fwdA_r <= nextFwdA_s;
      fwdB_r <= nextFwdB_s;
    end
  end

  assign fwd_a_sel = fwdA_r;
  assign fwd_b_sel = fwdB_r;
`else
  assign fwd_a_sel = FWD_W'(FWD_RF);
  assign fwd_b_sel = FWD_W'(FWD_RF);
`endif

endmodule
